// File: rtl/spi_pcm_stream_tx.sv
// spi_pcm_stream_tx
//   Buffered multi-channel PCM transmitter. The audio pipeline pushes whole
//   frames into a FIFO. An external SPI master (mode 0) clocks the frames
//   out MSB-first on sdo. Consecutive frames stream back to back inside one
//   cs_n assertion. sck and cs_n are asynchronous and are oversampled in clk.
//
// Parameters
//   SAMPLE_W    bits per channel sample
//   CHANNELS    channels per frame (FRAME_W = SAMPLE_W*CHANNELS)
//   FIFO_DEPTH  frames buffered (power of two, >= 2)
//
// Configuration macro
//   PCM_PARITY_EN  when defined, an even-parity bit (XOR of all FRAME_W data
//                  bits) follows the last LSB of every frame.
//
// Ports
//   clk, reset_n            system clock, asynchronous active-low reset
//   sck, cs_n               SPI clock / chip select from the master (async)
//   sdo                     serial data to the master
//   sample_valid/ready/data frame input; ch0 sits in sample_data[SAMPLE_W-1:0]
//   fifo_level              frames currently queued
//   underrun, underrun_clr  sticky empty-pop flag and its synchronous clear
//   frame_active            high while the shifter is in SHIFT
//
// Handshake: a frame is accepted on a rising clk edge where sample_valid and
// sample_ready are both high; sample_ready depends only on fifo_level.
module spi_pcm_stream_tx #(
  parameter int SAMPLE_W   = 16,
  parameter int CHANNELS   = 2,
  parameter int FIFO_DEPTH = 4,
  localparam int FRAME_W   = SAMPLE_W * CHANNELS,
  localparam int LVL_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               sck,
  input  logic               cs_n,
  output logic               sdo,
  input  logic               sample_valid,
  output logic               sample_ready,
  input  logic [FRAME_W-1:0] sample_data,
  output logic [LVL_W-1:0]   fifo_level,
  output logic               underrun,
  input  logic               underrun_clr,
  output logic               frame_active
);

`ifdef PCM_PARITY_EN
  localparam int FRAME_BITS = FRAME_W + 1;
`else
  localparam int FRAME_BITS = FRAME_W;
`endif
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FRAME_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t                  state, state_d;
  logic [FRAME_BITS-1:0]   shreg, shreg_d;
  logic [CNT_W-1:0]        bit_cnt, bit_cnt_d;
  logic                    pop_req;

  // Synchronisers: meta -> s (synchronised) -> d (previous, for edges).
  logic sck_meta, sck_s, sck_d;
  logic cs_meta, cs_s, cs_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sck_meta <= 1'b0;
      sck_s    <= 1'b0;
      sck_d    <= 1'b0;
      cs_meta  <= 1'b1;
      cs_s     <= 1'b1;
      cs_d     <= 1'b1;
    end else begin
      sck_meta <= sck;
      sck_s    <= sck_meta;
      sck_d    <= sck_s;
      cs_meta  <= cs_n;
      cs_s     <= cs_meta;
      cs_d     <= cs_s;
    end
  end

  logic sck_fall, cs_fall, cs_rise;
  assign sck_fall = sck_d & ~sck_s;
  assign cs_fall  = cs_d & ~cs_s;
  assign cs_rise  = ~cs_d & cs_s;

  // ---------------- FIFO ----------------
  logic [FRAME_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic               fifo_empty, push, pop, underrun_set;

  assign sample_ready = (fifo_level < LVL_W'(FIFO_DEPTH));
  assign fifo_empty   = (fifo_level == '0);
  assign push         = sample_valid & sample_ready;
  // An empty pop does not consume a frame pushed in the same cycle.
  assign pop          = pop_req & ~fifo_empty;
  assign underrun_set = pop_req & fifo_empty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sample_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      underrun   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
      if (underrun_set)      underrun <= 1'b1;
      else if (underrun_clr) underrun <= 1'b0;
    end
  end

  // Head frame rearranged into transmit order: ch0 occupies the top slice so
  // a plain MSB-first shift emits ch0 MSB..LSB, then ch1, and so on.
  logic [FRAME_W-1:0]    head_ser;
  logic [FRAME_BITS-1:0] load_word;

  always_comb begin
    head_ser = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      head_ser[FRAME_W-1-c*SAMPLE_W -: SAMPLE_W] = mem[rd_ptr][c*SAMPLE_W +: SAMPLE_W];
    end
  end

`ifdef PCM_PARITY_EN
  assign load_word = fifo_empty ? '0 : {head_ser, ^head_ser};
`else
  assign load_word = fifo_empty ? '0 : head_ser;
`endif

  // ---------------- Shifter FSM ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_d;
      shreg   <= shreg_d;
      bit_cnt <= bit_cnt_d;
    end
  end

  always_comb begin
    state_d   = state;
    shreg_d   = shreg;
    bit_cnt_d = bit_cnt;
    pop_req   = 1'b0;
    if (cs_rise) begin
      // Deselect aborts whatever is in flight; the partial frame is dropped.
      state_d   = IDLE;
      shreg_d   = '0;
      bit_cnt_d = '0;
    end else begin
      case (state)
        IDLE: begin
          shreg_d   = '0;
          bit_cnt_d = '0;
          if (cs_fall) state_d = LOAD;
        end
        LOAD: begin
          pop_req   = 1'b1;
          shreg_d   = load_word;
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
        SHIFT: begin
          if (sck_fall) begin
            if (bit_cnt == LAST_BIT) begin
              // Next frame follows immediately with no gap bit.
              pop_req   = 1'b1;
              shreg_d   = load_word;
              bit_cnt_d = '0;
            end else begin
              shreg_d   = {shreg[FRAME_BITS-2:0], 1'b0};
              bit_cnt_d = bit_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          state_d   = IDLE;
          shreg_d   = '0;
          bit_cnt_d = '0;
        end
      endcase
    end
  end

  assign sdo          = shreg[FRAME_BITS-1];
  assign frame_active = (state == SHIFT);

endmodule

// File: tb/tb_spi_pcm_stream_tx.sv
// tb_spi_pcm_stream_tx
//   Drives frames into spi_pcm_stream_tx and acts as a mode-0 SPI master.
//   A frame-level model (queue of pushed frames) produces the expected bit
//   stream whenever a new frame slot starts; a monitor compares sdo at
//   every sck rise against that stream.
module tb_spi_pcm_stream_tx;
  localparam int SW    = 16;
  localparam int CH    = 2;
  localparam int DEPTH = 4;
  localparam int FW    = SW * CH;
  localparam int LW    = $clog2(DEPTH + 1);
`ifdef PCM_PARITY_EN
  localparam int FB = FW + 1;
`else
  localparam int FB = FW;
`endif
  localparam int HALF = 50;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          sck = 1'b0;
  logic          cs_n = 1'b1;
  logic          sdo;
  logic          sample_valid = 1'b0;
  logic          sample_ready;
  logic [FW-1:0] sample_data = '0;
  logic [LW-1:0] fifo_level;
  logic          underrun;
  logic          underrun_clr = 1'b0;
  logic          frame_active;

  spi_pcm_stream_tx #(.SAMPLE_W(SW), .CHANNELS(CH), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .sck(sck), .cs_n(cs_n), .sdo(sdo),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .sample_data(sample_data), .fifo_level(fifo_level),
    .underrun(underrun), .underrun_clr(underrun_clr),
    .frame_active(frame_active)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- model / scoreboard ----------------
  int            checks = 0;
  int            failures = 0;
  logic [FW-1:0] m_q[$];        // frames the DUT should hold
  logic          m_underrun = 1'b0;
  logic [0:0]    exp_q[$];      // expected sdo bits, in send order
  int            bit_pos = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Start of a frame slot: take the oldest frame (zeros on underrun) and
  // list its bits: ch0 MSB..LSB, ch1 MSB..LSB, then parity if enabled.
  task automatic fetch_frame();
    logic [FW-1:0] f;
    if (m_q.size() > 0) f = m_q.pop_front();
    else begin
      f = '0;
      m_underrun = 1'b1;
    end
    for (int c = 0; c < CH; c++)
      for (int b = SW - 1; b >= 0; b--)
        exp_q.push_back(f[c*SW + b]);
`ifdef PCM_PARITY_EN
    exp_q.push_back(^f);
`endif
  endtask

  // Monitor: mode-0 master samples sdo on sck rise.
  always @(posedge sck) begin
    if (cs_n === 1'b0 && reset_n === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sdo_extra_bit actual=%0b expected=none @%0t", sdo, $time);
      end else begin
        logic [0:0] e;
        e = exp_q.pop_front();
        if (sdo !== e) begin
          failures++;
          $display("FAIL sdo_bit actual=%0b expected=%0b @%0t", sdo, e, $time);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_frame(input logic [FW-1:0] d);
    int waited = 0;
    @(negedge clk);
    sample_valid = 1'b1;
    sample_data  = d;
    while (!sample_ready && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    if (!sample_ready) begin
      checks++;
      failures++;
      $display("FAIL push_timeout actual=ready0 expected=ready1 @%0t", $time);
    end else begin
      @(posedge clk);
      m_q.push_back(d);
    end
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic cs_begin();
    @(negedge clk);
    cs_n = 1'b0;
    bit_pos = 0;
    #(2 * HALF);
    check("frame_active_on", {31'd0, frame_active}, 32'd1);
  endtask

  task automatic clock_bit();
    if (bit_pos % FB == 0) fetch_frame();
    if (sck) begin
      sck = 1'b0;
      #HALF;
    end
    sck = 1'b1;
    #HALF;
    bit_pos++;
  endtask

  // Deselect while sck is still high, then park sck low.
  task automatic cs_end();
    cs_n = 1'b1;
    #HALF;
    sck = 1'b0;
    repeat (6) @(negedge clk);
    exp_q.delete();
    bit_pos = 0;
  endtask

  task automatic xfer(input int nbits);
    cs_begin();
    repeat (nbits) clock_bit();
    cs_end();
  endtask

  task automatic clear_underrun();
    @(negedge clk);
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    m_underrun = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_sdo"},          {31'd0, sdo},          32'd0);
    check({tag, "_ready"},        {31'd0, sample_ready}, 32'd1);
    check({tag, "_level"},        32'(fifo_level),       32'd0);
    check({tag, "_underrun"},     {31'd0, underrun},     32'd0);
    check({tag, "_frame_active"}, {31'd0, frame_active}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #23;
    check_reset_values("reset");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // Known frame: ch0=1234 goes out first, then ch1=BEEF.
    push_frame({16'hBEEF, 16'h1234});
    check("t1_level_before", 32'(fifo_level), 32'd1);
    xfer(FB);
    check("t1_level_after", 32'(fifo_level), 32'd0);
    check("t1_underrun", {31'd0, underrun}, {31'd0, m_underrun});

    // Two frames streamed contiguously.
    push_frame($urandom);
    push_frame($urandom);
    xfer(2 * FB);
    check("t2_underrun", {31'd0, underrun}, 32'd0);
    check("t2_level", 32'(fifo_level), 32'd0);

    // Empty FIFO: zeros and sticky underrun.
    xfer(FB);
    check("t3_underrun_set", {31'd0, underrun}, {31'd0, m_underrun});
    clear_underrun();
    check("t3_underrun_clr", {31'd0, underrun}, 32'd0);

    // Full FIFO holds off the fifth frame until one is popped.
    for (int i = 0; i < DEPTH; i++) push_frame($urandom);
    check("t4_ready_full", {31'd0, sample_ready}, 32'd0);
    check("t4_level_full", 32'(fifo_level), 32'(DEPTH));
    fork
      push_frame($urandom);
      begin
        repeat (5) @(negedge clk);
        check("t4_held_level", 32'(fifo_level), 32'(DEPTH));
        xfer(FB);
      end
    join
    check("t4_level_refill", 32'(fifo_level), 32'(DEPTH));
    xfer(DEPTH * FB);
    check("t4_level_drained", 32'(fifo_level), 32'd0);
    check("t4_underrun", {31'd0, underrun}, 32'd0);

    // Abort after 10 bits; the next selection starts the next frame.
    push_frame($urandom);
    push_frame($urandom);
    xfer(10);
    check("t5_idle_frame_active", {31'd0, frame_active}, 32'd0);
    check("t5_idle_sdo", {31'd0, sdo}, 32'd0);
    check("t5_level_after_abort", 32'(fifo_level), 32'd1);
    xfer(FB);
    check("t5_level", 32'(fifo_level), 32'd0);

    // Randomised bursts, sometimes clocking one slot past the data.
    for (int r = 0; r < 6; r++) begin
      int n;
      int extra;
      n = $urandom_range(1, DEPTH);
      extra = ($urandom_range(0, 2) == 0) ? FB : 0;
      for (int i = 0; i < n; i++) push_frame($urandom);
      xfer(n * FB + extra);
      check("rand_underrun", {31'd0, underrun}, {31'd0, m_underrun});
      check("rand_level", 32'(fifo_level), 32'd0);
      clear_underrun();
    end

    // Single-bit frame (parity bit is 1 when enabled).
    push_frame(32'h0000_0001);
    xfer(FB);

    // Reset in the middle of a frame.
    push_frame($urandom);
    push_frame($urandom);
    cs_begin();
    repeat (5) clock_bit();
    @(negedge clk);
    reset_n = 1'b0;
    #2;
    check_reset_values("midreset");
    cs_n = 1'b1;
    sck = 1'b0;
    exp_q.delete();
    bit_pos = 0;
    m_q.delete();
    m_underrun = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // Normal operation resumes after reset.
    push_frame($urandom);
    xfer(FB);
    check("post_reset_underrun", {31'd0, underrun}, 32'd0);
    check("post_reset_level", 32'(fifo_level), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
